// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the async FIFO: issues reads against fifo_empty, absorbs the
// one-cycle read latency in a 2-entry buffer and re-presents words as a framed stream.
module fifo_stream_reader #(
  parameter int DATA_LEN  = 16,
  parameter int BURST_LEN = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [DATA_LEN-1:0] fifo_data,
  output logic                read_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_last,
  output logic [31:0]         word_count
);

  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t                r_occ;
  occ_t                w_occ_next;
  logic                r_inflight;
  logic                r_run;
  logic [DATA_LEN-1:0] r_head;
  logic [DATA_LEN-1:0] r_tail;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [31:0]         r_word_count;

  logic                w_push;
  logic                w_pop;
  logic                w_to_head;
  logic [2:0]          w_occ_cnt;
  logic [2:0]          w_level;

  assign w_push = r_inflight;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_occ_cnt = 3'd0;
    case (r_occ)
      S_ONE:   w_occ_cnt = 3'd1;
      S_TWO:   w_occ_cnt = 3'd2;
      default: w_occ_cnt = 3'd0;
    endcase
  end

  // Words that will be held after this cycle if no new read is issued.
  assign w_level = w_occ_cnt + {2'b00, r_inflight} - {2'b00, w_pop};

  // r_run keeps read_en low while reset is asserted and releases it on the first edge after.
  assign read_en = r_run && enable && !fifo_empty && (w_level < 3'd2);

  always_comb begin
    w_occ_next = r_occ;
    w_to_head  = 1'b0;
    case (r_occ)
      S_EMPTY: begin
        w_to_head = 1'b1;
        if (w_push) begin
          w_occ_next = S_ONE;
        end
      end
      S_ONE: begin
        w_to_head = w_pop;
        if (w_push && !w_pop) begin
          w_occ_next = S_TWO;
        end else if (!w_push && w_pop) begin
          w_occ_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_pop && !w_push) begin
          w_occ_next = S_ONE;
        end
      end
      default: w_occ_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ      <= S_EMPTY;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= read_en;
      r_run      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push && w_to_head) begin
        r_head <= fifo_data;
      end else if (w_pop && (r_occ == S_TWO)) begin
        r_head <= r_tail;
      end
      if (w_push && !w_to_head) begin
        r_tail <= fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt       <= '0;
      r_word_count <= '0;
    end else if (w_pop) begin
      r_word_count <= r_word_count + 32'd1;
      if (r_bcnt == BCNT_MAX) begin
        r_bcnt <= '0;
      end else begin
        r_bcnt <= r_bcnt + BCNT_W'(1);
      end
    end
  end

  assign out_valid  = (r_occ != S_EMPTY);
  assign out_data   = r_head;
  assign out_last   = out_valid && (r_bcnt == BCNT_MAX);
  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard of expected words and
// burst framing, plus a per-cycle vector table for the single-word corner case.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
  localparam int DATA_LEN  = 16;
  localparam int BURST_LEN = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                fifo_empty;
  logic [DATA_LEN-1:0] fifo_data;
  logic                read_en;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic                out_last;
  logic [31:0]         word_count;
  logic                rd_q;

  typedef struct {
    logic [DATA_LEN-1:0] d;
    logic                l;
  } exp_t;

  typedef struct {
    logic                push;
    logic [DATA_LEN-1:0] val;
    logic                en;
    logic                rdy;
    logic                exp_rd;
    logic                exp_vld;
    logic [DATA_LEN-1:0] exp_d;
    logic                exp_l;
  } vec_t;

  exp_t                exp_q[$];
  logic [DATA_LEN-1:0] fifo_q[$];
  vec_t                vt[6];

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_bcnt   = 0;
  int unsigned m_wc     = 0;
  int          pops     = 0;
  int          rd_cnt   = 0;
  logic                hold_pending = 1'b0;
  logic [DATA_LEN-1:0] held_d = '0;
  logic                held_l = 1'b0;

  fifo_stream_reader #(.DATA_LEN(DATA_LEN), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .read_en    (read_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // The FIFO serves a read on the cycle after read_en was sampled high.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= 1'b0;
    else          rd_q <= read_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!reset_n) begin
      hold_pending = 1'b0;
      return;
    end
    check("rd_vs_empty", 32'(read_en && fifo_empty), 32'd0);
    if (hold_pending) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(held_d));
      check("hold_last", 32'(out_last), 32'(held_l));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("stream_data", 32'(out_data), 32'(e.d));
        check("stream_last", 32'(out_last), 32'(e.l));
      end
      check("word_count", word_count, 32'(m_wc));
      m_wc++;
      pops++;
    end
    hold_pending = out_valid && !out_ready;
    held_d       = out_data;
    held_l       = out_last;
    if (read_en) rd_cnt++;
  endtask

  task automatic wait_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_pos();
    @(posedge clk);
    #1;
    if (rd_q && (fifo_q.size() > 0)) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic tick();
    wait_neg();
    wait_pos();
  endtask

  task automatic fifo_push(input logic [DATA_LEN-1:0] v);
    exp_t e;
    fifo_q.push_back(v);
    fifo_empty = 1'b0;
    e.d = v;
    e.l = (m_bcnt == BURST_LEN - 1);
    exp_q.push_back(e);
    m_bcnt = (m_bcnt == BURST_LEN - 1) ? 0 : m_bcnt + 1;
  endtask

  task automatic drain(input string name, input int budget, input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    out_ready = 1'b1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, no summary");
    $fatal(1);
  end

  initial begin
    int first_rd, first_vld, last_vld, nvld, rd0, p0;

    // push, val, en, rdy, exp_rd, exp_vld, exp_d, exp_l
    vt[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

    reset_n    = 1'b1;
    enable     = 1'b1;
    out_ready  = 1'b1;
    fifo_data  = '0;
    fifo_empty = 1'b1;
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'h5A00 + 16'(i));
    fifo_empty = 1'b0;

    // Reset held with a non-empty FIFO and enable high
    for (int i = 0; i < 3; i++) begin
      wait_neg();
      check("reset_read_en", 32'(read_en), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_word_count", word_count, 32'd0);
      wait_pos();
    end
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    fifo_q.delete();
    fifo_empty = 1'b1;
    reset_n    = 1'b1;
    tick();
    tick();

    // Streaming 0..511 at full rate
    enable = 1'b0;
    for (int i = 0; i < 512; i++) fifo_push(16'(i));
    tick();
    enable    = 1'b1;
    first_rd  = -1;
    first_vld = -1;
    last_vld  = -1;
    nvld      = 0;
    for (int cyc = 0; (cyc < 700) && (exp_q.size() != 0); cyc++) begin
      wait_neg();
      if (read_en && (first_rd < 0)) first_rd = cyc;
      if (out_valid) begin
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
        nvld++;
      end
      wait_pos();
    end
    check("stream_done", 32'(exp_q.size()), 32'd0);
    check("stream_latency", 32'(first_vld - first_rd), 32'd2);
    check("stream_valid_cycles", 32'(nvld), 32'd512);
    check("stream_no_bubbles", 32'(last_vld - first_vld), 32'd511);
    tick();
    check("stream_word_count", word_count, 32'd512);

    // Empty FIFO with enable high
    for (int i = 0; i < 50; i++) begin
      wait_neg();
      check("empty_idle", 32'({read_en, out_valid}), 32'd0);
      wait_pos();
    end

    // Single word 0xBEEF, cycle by cycle
    rd0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      enable    = vt[i].en;
      out_ready = vt[i].rdy;
      if (vt[i].push) fifo_push(vt[i].val);
      wait_neg();
      check($sformatf("vec%0d_read_en", i), 32'(read_en), 32'(vt[i].exp_rd));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_vld));
      if (vt[i].exp_vld) begin
        check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp_d));
        check($sformatf("vec%0d_last", i), 32'(out_last), 32'(vt[i].exp_l));
      end
      wait_pos();
    end
    check("single_read_pulses", 32'(rd_cnt - rd0), 32'd1);

    // Back-pressure from an empty buffer, then random ready
    out_ready = 1'b0;
    enable    = 1'b1;
    rd0       = rd_cnt;
    for (int i = 0; i < 40; i++) fifo_push(16'h1000 + 16'(i));
    for (int i = 0; i < 20; i++) tick();
    check("bp_reads", 32'(rd_cnt - rd0), 32'd2);
    check("bp_valid", 32'(out_valid), 32'd1);
    drain("bp_drain", 2000, 1'b1);

    // Enable dropped right after the second read pulse
    out_ready = 1'b0;
    enable    = 1'b1;
    rd0       = rd_cnt;
    fifo_push(16'h2000);
    fifo_push(16'h2001);
    tick();
    tick();
    check("ed_reads", 32'(rd_cnt - rd0), 32'd2);
    enable = 1'b0;
    for (int i = 0; i < 18; i++) fifo_push(16'h2002 + 16'(i));
    wait_neg();
    check("ed_read_off", 32'(read_en), 32'd0);
    wait_pos();
    p0        = pops;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_neg();
      check("ed_read_off", 32'(read_en), 32'd0);
      wait_pos();
    end
    check("ed_delivered", 32'(pops - p0), 32'd2);
    check("ed_valid_low", 32'(out_valid), 32'd0);
    enable = 1'b1;
    drain("ed_drain", 200, 1'b0);

    // Asynchronous reset mid-burst
    tick();
    out_ready = 1'b1;
    enable    = 1'b1;
    p0        = pops;
    for (int i = 0; i < 20; i++) fifo_push(16'(200 + i));
    for (int n = 0; (n < 50) && ((pops - p0) < 8); n++) tick();
    check("rmb_pops", 32'(pops - p0), 32'd8);
    #2;
    reset_n = 1'b0;
    #1;
    check("rmb_valid", 32'(out_valid), 32'd0);
    check("rmb_read_en", 32'(read_en), 32'd0);
    check("rmb_data", 32'(out_data), 32'd0);
    check("rmb_last", 32'(out_last), 32'd0);
    check("rmb_word_count", word_count, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    m_bcnt       = 0;
    m_wc         = 0;
    fifo_empty   = 1'b1;
    hold_pending = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) fifo_push(16'(100 + i));
    drain("rmb_refill", 200, 1'b0);
    tick();
    check("rmb_refill_count", word_count, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
